// File: rtl/sig_pkg.sv
// Shared sigmoid-path constants: default widths agreed with the sigmoid ROM
// and the default requester count of one MLP layer.
package sig_pkg;

  localparam int SIG_IN_WIDTH   = 10;
  localparam int SIG_DATA_WIDTH = 16;
  localparam int SIG_N_REQ      = 4;
  localparam int SIG_ROM_LAT    = 2;
  localparam int SIG_IDX_W      = $clog2(SIG_N_REQ);

  // Lookup tag at the default requester count; the top re-declares it at its
  // own width so non-default N_REQ still works.
  typedef struct packed {
    logic                 valid;
    logic [SIG_IDX_W-1:0] idx;
  } sig_tag_t;

endpackage

// File: rtl/rr_select.sv
// Combinational rotate-priority picker: first set bit of 'eligible' searching
// upward from 'ptr' with wrap-around.
module rr_select #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [N-1:0]     gnt_oh,
  output logic [IDX_W-1:0] idx
);

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    gnt_oh = '0;
    // Walk from the farthest offset back to ptr so the nearest hit wins.
    for (int i = N - 1; i >= 0; i--) begin
      int cand;
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (eligible[cand]) begin
        any = 1'b1;
        idx = IDX_W'(cand);
      end
    end
    if (any) gnt_oh[idx] = 1'b1;
  end

endmodule

// File: rtl/sig_rom_arbiter.sv
// Round-robin sharing of one sigmoid ROM among N_REQ neurons: one grant per
// cycle, tags follow each lookup through the ROM latency back to its owner.
module sig_rom_arbiter
  import sig_pkg::*;
#(
  parameter int N_REQ      = SIG_N_REQ,
  parameter int IN_WIDTH   = SIG_IN_WIDTH,
  parameter int DATA_WIDTH = SIG_DATA_WIDTH,
  parameter int ROM_LAT    = SIG_ROM_LAT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*IN_WIDTH-1:0] x_in,
  output logic [N_REQ-1:0]          gnt,
  output logic [IN_WIDTH-1:0]       rom_x,
  input  logic [DATA_WIDTH-1:0]     rom_out,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic                      busy
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  logic [IDX_W-1:0]    ptr;
  logic [N_REQ-1:0]    pending;
  logic [N_REQ-1:0]    pending_nxt;
  logic [N_REQ-1:0]    eligible;
  logic                sel_any;
  logic [N_REQ-1:0]    sel_oh;
  logic [IDX_W-1:0]    sel_idx;
  logic [IDX_W-1:0]    ptr_nxt;
  logic [IN_WIDTH-1:0] x_sel;
  logic [N_REQ-1:0]    rsp_oh;

  // issue_tag travels alongside rom_x; tag_pipe then mirrors the ROM's
  // internal latency so its last stage lines up with rom_out.
  tag_t issue_tag;
  tag_t tag_pipe [ROM_LAT];
  tag_t tag_last;

  assign eligible = req & ~pending;
  assign tag_last = tag_pipe[ROM_LAT-1];

  rr_select #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .eligible (eligible),
    .ptr      (ptr),
    .any      (sel_any),
    .gnt_oh   (sel_oh),
    .idx      (sel_idx)
  );

  assign x_sel   = x_in[int'(sel_idx)*IN_WIDTH +: IN_WIDTH];
  assign ptr_nxt = (sel_idx == IDX_W'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;

  // Release and new grant never hit the same index in one cycle: a granted
  // index must be non-pending, a released one is pending.
  always_comb begin
    pending_nxt = pending;
    rsp_oh      = '0;
    if (tag_last.valid) begin
      pending_nxt[tag_last.idx] = 1'b0;
      rsp_oh[tag_last.idx]      = 1'b1;
    end
    if (sel_any) pending_nxt[sel_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      pending   <= '0;
      gnt       <= '0;
      rom_x     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      issue_tag <= '0;
      // NOTE: the tag pipe is a handful of flops, not a RAM, so it is reset
      // element by element; this is what drops in-flight lookups on reset.
      for (int i = 0; i < ROM_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      gnt       <= sel_oh;
      pending   <= pending_nxt;
      busy      <= |pending_nxt;
      rsp_valid <= rsp_oh;
      issue_tag <= '{valid: sel_any, idx: sel_idx};
      tag_pipe[0] <= issue_tag;
      for (int i = 1; i < ROM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      if (sel_any) begin
        rom_x <= x_sel;
        ptr   <= ptr_nxt;
      end
      if (tag_last.valid) rsp_data <= rom_out;
    end
  end

endmodule

// File: tb/tb_sig_rom_arbiter.sv
// Directed bench for sig_rom_arbiter with a two-stage ROM model (x + 100).
module tb_sig_rom_arbiter;

  localparam int N  = 4;
  localparam int IW = 10;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [IW-1:0]     xv [N];
  logic [N*IW-1:0]   x_in;
  logic [N-1:0]      gnt;
  logic [IW-1:0]     rom_x;
  logic [DW-1:0]     rom_out = '0;
  logic [DW-1:0]     rom_s1  = '0;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign x_in = {xv[3], xv[2], xv[1], xv[0]};

  // ROM model: two registered stages, output = sign-extended x + 100.
  always_ff @(posedge clk) begin
    rom_s1  <= {{(DW-IW){rom_x[IW-1]}}, rom_x} + 16'd100;
    rom_out <= rom_s1;
  end

  sig_rom_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .x_in      (x_in),
    .gnt       (gnt),
    .rom_x     (rom_x),
    .rom_out   (rom_out),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    for (int i = 0; i < N; i++) xv[i] = '0;

    // 1. Reset behaviour
    xv[0] = 10'd7;
    req   = 4'b1111;
    tick();
    check("rst_gnt",       gnt,       4'b0000);
    check("rst_rom_x",     rom_x,     10'h000);
    check("rst_rsp_valid", rsp_valid, 4'b0000);
    check("rst_rsp_data",  rsp_data,  16'h0000);
    check("rst_busy",      busy,      1'b0);
    rst_n = 1'b1;
    tick();
    check("t1_gnt0",   gnt,   4'b0001);
    check("t1_rom_x",  rom_x, 10'd7);
    check("t1_busy",   busy,  1'b1);
    req = 4'b0000;
    tick();
    check("t1_gnt_c2", gnt, 4'b0000);
    tick();
    tick();
    check("t1_rsp_valid", rsp_valid, 4'b0001);
    check("t1_rsp_data",  rsp_data,  16'd107);
    tick();
    check("t1_busy_idle", busy, 1'b0);

    // 2. Single lookup latency and re-grant of a held request
    do_reset();
    xv[2] = 10'h3FB;
    req   = 4'b0100;
    tick();
    check("t2_gnt_c1",   gnt,   4'b0100);
    check("t2_rom_x_c1", rom_x, 10'h3FB);
    tick();
    check("t2_gnt_c2", gnt,       4'b0000);
    check("t2_rsp_c2", rsp_valid, 4'b0000);
    tick();
    check("t2_gnt_c3", gnt,       4'b0000);
    check("t2_rsp_c3", rsp_valid, 4'b0000);
    tick();
    check("t2_gnt_c4",      gnt,       4'b0000);
    check("t2_rsp_c4",      rsp_valid, 4'b0100);
    check("t2_rsp_data_c4", rsp_data,  16'd95);
    tick();
    check("t2_regnt_c5", gnt,       4'b0100);
    check("t2_rsp_c5",   rsp_valid, 4'b0000);
    req = 4'b0000;

    // 3. Full contention
    do_reset();
    xv[0] = 10'd10;
    xv[1] = -10'sd20;
    xv[2] = 10'd30;
    xv[3] = -10'sd40;
    req   = 4'b1111;
    tick();
    check("t3_gnt_c1", gnt, 4'b0001);
    req = 4'b1110;
    tick();
    check("t3_gnt_c2", gnt, 4'b0010);
    req = 4'b1100;
    tick();
    check("t3_gnt_c3", gnt, 4'b0100);
    req = 4'b1000;
    tick();
    check("t3_gnt_c4",  gnt,       4'b1000);
    check("t3_rsp_c4",  rsp_valid, 4'b0001);
    check("t3_data_c4", rsp_data,  16'd110);
    req = 4'b0000;
    tick();
    check("t3_gnt_c5",  gnt,       4'b0000);
    check("t3_rsp_c5",  rsp_valid, 4'b0010);
    check("t3_data_c5", rsp_data,  16'd80);
    tick();
    check("t3_rsp_c6",  rsp_valid, 4'b0100);
    check("t3_data_c6", rsp_data,  16'd130);
    tick();
    check("t3_rsp_c7",  rsp_valid, 4'b1000);
    check("t3_data_c7", rsp_data,  16'd60);
    tick();
    check("t3_busy_c8", busy, 1'b0);

    // 4. Pointer wrap and fairness: grants at c%4==1 (n0) and c%4==2 (n3)
    do_reset();
    req = 4'b1001;
    for (int c = 1; c <= 20; c++) begin
      logic [N-1:0] exp_gnt;
      tick();
      exp_gnt = (c % 4 == 1) ? 4'b0001 : (c % 4 == 2) ? 4'b1000 : 4'b0000;
      check($sformatf("t4_gnt_c%0d", c), gnt, exp_gnt);
    end
    req = 4'b0000;

    // 5. Reset mid-flight
    do_reset();
    xv[1] = 10'd55;
    req   = 4'b0010;
    tick();
    check("t5_gnt_c1", gnt, 4'b0010);
    tick();
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    check("t5_busy_in_rst", busy, 1'b0);
    check("t5_gnt_in_rst",  gnt,  4'b0000);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("t5_rsp_after_%0d", c),  rsp_valid, 4'b0000);
      check($sformatf("t5_busy_after_%0d", c), busy,      1'b0);
    end

    // 6. Boundary input codes
    do_reset();
    xv[0] = 10'h200;
    xv[3] = 10'h1FF;
    req   = 4'b1001;
    tick();
    check("t6_gnt_c1",   gnt,   4'b0001);
    check("t6_rom_x_c1", rom_x, 10'h200);
    req = 4'b1000;
    tick();
    check("t6_gnt_c2",   gnt,   4'b1000);
    check("t6_rom_x_c2", rom_x, 10'h1FF);
    req = 4'b0000;
    tick();
    tick();
    check("t6_rsp_c4",  rsp_valid, 4'b0001);
    check("t6_data_c4", rsp_data,  16'hFE64);
    tick();
    check("t6_rsp_c5",  rsp_valid, 4'b1000);
    check("t6_data_c5", rsp_data,  16'h0263);
    tick();
    check("t6_rsp_c6",  rsp_valid, 4'b0000);
    check("t6_hold_c6", rsp_data,  16'h0263);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
